// File: rtl/nes_ctrl_pkg.sv
// Shared definitions for the game-pad poller.
//   poll_state_t : poller FSM encoding
//   NES_BITS / SNES_BITS : standard shift lengths
//   BTN_* : NES button bit positions inside one pad's word
//   max_int : helper for sizing counters
package nes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } poll_state_t;

    localparam int NES_BITS  = 8;
    localparam int SNES_BITS = 16;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (clears both stages)
//   d     : asynchronous input bus
//   q     : synchronised output, two clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ctrl_poller.sv
// Game-pad serial poller: strobes all pads, clocks their shift registers
// and assembles one parallel button word per pad, plus newly-pressed bits.
//   clk_nes     : block clock
//   rst_nes_n   : asynchronous active-low reset, aborts any poll in flight
//   poll_req    : single-cycle poll start
//   ctrl_data   : raw serial data per pad (asynchronous)
//   ctrl_strobe : latch pulse to all pads
//   ctrl_clk    : shift clock per pad, all identical
//   buttons     : pad p bit i at [p*NUM_BITS+i], 1 = pressed
//   pressed     : buttons & ~previous buttons, updated with valid
//   valid       : one-cycle pulse when buttons/pressed update
//   busy        : poll in progress (first strobe cycle through DONE)
//   overrun     : one-cycle pulse, trigger arrived while busy and was dropped
//
// Handshake: poll_req/auto trigger is a fire-and-forget pulse; it is accepted
// only in IDLE, otherwise it is dropped and reported via overrun one cycle
// later. valid is a pulse with no back-pressure; buttons/pressed hold until
// the next valid.
module ctrl_poller
    import nes_ctrl_pkg::*;
#(
    parameter int NUM_PADS        = 2,
    parameter int NUM_BITS        = 8,
    parameter int STROBE_CYCLES   = 12,
    parameter int HALF_PERIOD     = 6,
    parameter int AUTO_PERIOD     = 0,
    parameter int DATA_ACTIVE_LOW = 1,
    parameter int CLK_IDLE_HIGH   = 0
) (
    input  logic                         clk_nes,
    input  logic                         rst_nes_n,
    input  logic                         poll_req,
    input  logic [NUM_PADS-1:0]          ctrl_data,
    output logic                         ctrl_strobe,
    output logic [NUM_PADS-1:0]          ctrl_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic                         valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int WW      = NUM_PADS * NUM_BITS;
    localparam int CNT_MAX = max_int(STROBE_CYCLES, HALF_PERIOD);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_BITS);

    localparam logic CLK_IDLE_LVL = (CLK_IDLE_HIGH != 0);
    localparam logic CLK_ACT_LVL  = ~CLK_IDLE_LVL;
    localparam logic DATA_INV     = (DATA_ACTIVE_LOW != 0);

    poll_state_t          state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_q;
    logic [WW-1:0]        shift_q, word_next;
    logic [NUM_PADS-1:0]  data_sync, sample;
    logic                 auto_trig, trigger;
    logic                 last_bit, sample_en, bit_adv;

    sync_2ff #(.WIDTH(NUM_PADS)) u_sync (
        .clk   (clk_nes),
        .rst_n (rst_nes_n),
        .d     (ctrl_data),
        .q     (data_sync)
    );

    // Normalise line polarity so 1 always means pressed.
    assign sample = data_sync ^ {NUM_PADS{DATA_INV}};

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int TW = $clog2(AUTO_PERIOD + 1);
            logic [TW-1:0] timer_q;

            always_ff @(posedge clk_nes or negedge rst_nes_n) begin
                if (!rst_nes_n) begin
                    timer_q <= '0;
                end else if (timer_q == TW'(AUTO_PERIOD - 1)) begin
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end

            assign auto_trig = (timer_q == TW'(AUTO_PERIOD - 1));
        end else begin : g_no_auto
            assign auto_trig = 1'b0;
        end
    endgenerate

    assign trigger  = poll_req | auto_trig;
    assign last_bit = (bit_q == IW'(NUM_BITS - 1));

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        sample_en = 1'b0;
        bit_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == CW'(STROBE_CYCLES - 1)) state_d = ST_CLK_LO;
            end
            ST_CLK_LO: begin
                // Sample on the last low cycle so the pad's new bit has had
                // a full half period to cross the synchroniser.
                if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    sample_en = 1'b1;
                    state_d   = last_bit ? ST_DONE : ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    bit_adv = 1'b1;
                    state_d = ST_CLK_LO;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word with the current sample merged in at bit index bit_q of every pad.
    always_comb begin
        word_next = shift_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            word_next[p*NUM_BITS + int'(bit_q)] = sample[p];
        end
    end

    always_ff @(posedge clk_nes or negedge rst_nes_n) begin
        if (!rst_nes_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || (state_q == ST_IDLE)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == ST_IDLE) begin
                bit_q <= '0;
            end else if (bit_adv) begin
                bit_q <= bit_q + IW'(1);
            end
            if ((state_q == ST_IDLE) && trigger) begin
                shift_q <= '0;
            end else if (sample_en) begin
                shift_q <= word_next;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe and come out glitch-free. buttons is written on the
    // final sample edge so it is already current while valid is high.
    always_ff @(posedge clk_nes or negedge rst_nes_n) begin
        if (!rst_nes_n) begin
            ctrl_strobe <= 1'b0;
            ctrl_clk    <= {NUM_PADS{CLK_IDLE_LVL}};
            buttons     <= '0;
            pressed     <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            ctrl_strobe <= (state_d == ST_STROBE);
            ctrl_clk    <= (state_d == ST_CLK_HI) ? {NUM_PADS{CLK_ACT_LVL}}
                                                  : {NUM_PADS{CLK_IDLE_LVL}};
            valid       <= (state_d == ST_DONE);
            busy        <= (state_d != ST_IDLE);
            overrun     <= trigger && (state_q != ST_IDLE);
            if (sample_en && last_bit) begin
                buttons <= word_next;
                pressed <= word_next & ~buttons;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_poller.sv
module tb_ctrl_poller;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance (2 pads, NES, active-low data)
    logic        poll_req;
    logic [1:0]  dut_data;
    logic        dut_strobe;
    logic [1:0]  dut_clk;
    logic [15:0] dut_buttons, dut_pressed;
    logic        dut_valid, dut_busy, dut_overrun;
    logic [7:0]  pad_word [2];
    logic [7:0]  pad_sh [2];

    ctrl_poller u_dut (
        .clk_nes     (clk),
        .rst_nes_n   (rst_n),
        .poll_req    (poll_req),
        .ctrl_data   (dut_data),
        .ctrl_strobe (dut_strobe),
        .ctrl_clk    (dut_clk),
        .buttons     (dut_buttons),
        .pressed     (dut_pressed),
        .valid       (dut_valid),
        .busy        (dut_busy),
        .overrun     (dut_overrun)
    );

    // 4021-style pad: latch on strobe, shift on shift-clock rising edge.
    always @(posedge dut_strobe or posedge dut_clk[0]) begin
        for (int p = 0; p < 2; p++) begin
            if (dut_strobe) pad_sh[p] = pad_word[p];
            else            pad_sh[p] = pad_sh[p] >> 1;
        end
    end
    assign dut_data = {~pad_sh[1][0], ~pad_sh[0][0]};

    // ---------------- SNES instance with auto-poll
    logic        snes_poll;
    logic [3:0]  snes_data;
    logic        snes_strobe;
    logic [3:0]  snes_clk;
    logic [63:0] snes_buttons, snes_pressed;
    logic        snes_valid, snes_busy, snes_overrun;
    logic [15:0] snes_word [4];
    logic [15:0] snes_sh [4];

    ctrl_poller #(.NUM_PADS(4), .NUM_BITS(16), .AUTO_PERIOD(1000)) u_snes (
        .clk_nes     (clk),
        .rst_nes_n   (rst_n),
        .poll_req    (snes_poll),
        .ctrl_data   (snes_data),
        .ctrl_strobe (snes_strobe),
        .ctrl_clk    (snes_clk),
        .buttons     (snes_buttons),
        .pressed     (snes_pressed),
        .valid       (snes_valid),
        .busy        (snes_busy),
        .overrun     (snes_overrun)
    );

    always @(posedge snes_strobe or posedge snes_clk[0]) begin
        for (int p = 0; p < 4; p++) begin
            if (snes_strobe) snes_sh[p] = snes_word[p];
            else             snes_sh[p] = snes_sh[p] >> 1;
        end
    end
    always_comb begin
        snes_data = '0;
        for (int p = 0; p < 4; p++) snes_data[p] = ~snes_sh[p][0];
    end

    // ---------------- inverted instance: clock idles high, data active-high
    logic        poll_inv;
    logic [1:0]  inv_data;
    logic        inv_strobe;
    logic [1:0]  inv_clk;
    logic [15:0] inv_buttons, inv_pressed;
    logic        inv_valid, inv_busy, inv_overrun;
    logic [7:0]  inv_word [2];
    logic [7:0]  inv_sh [2];

    ctrl_poller #(.CLK_IDLE_HIGH(1), .DATA_ACTIVE_LOW(0)) u_inv (
        .clk_nes     (clk),
        .rst_nes_n   (rst_n),
        .poll_req    (poll_inv),
        .ctrl_data   (inv_data),
        .ctrl_strobe (inv_strobe),
        .ctrl_clk    (inv_clk),
        .buttons     (inv_buttons),
        .pressed     (inv_pressed),
        .valid       (inv_valid),
        .busy        (inv_busy),
        .overrun     (inv_overrun)
    );

    always @(posedge inv_strobe or negedge inv_clk[0]) begin
        for (int p = 0; p < 2; p++) begin
            if (inv_strobe) inv_sh[p] = inv_word[p];
            else            inv_sh[p] = inv_sh[p] >> 1;
        end
    end
    assign inv_data = {inv_sh[1][0], inv_sh[0][0]};

    // ---------------- results of one observed poll on u_dut
    int          r_strobe_first, r_strobe_last, r_valid_at, r_nvalid;
    int          r_npulses, r_busy_first, r_busy_last, r_overrun_at;
    logic [15:0] r_btn_at_valid;

    // Pulse poll_req (sampled at edge k) and watch cycles k+1..k+130.
    // inject_at = c re-raises poll_req so it is sampled at edge k+c.
    task automatic run_poll(input int inject_at);
        logic prev_clk;
        r_strobe_first = -1; r_strobe_last = -1; r_valid_at = -1; r_nvalid = 0;
        r_npulses = 0; r_busy_first = -1; r_busy_last = -1; r_overrun_at = -1;
        r_btn_at_valid = '0;
        @(negedge clk);
        poll_req = 1'b1;
        @(posedge clk);
        prev_clk = dut_clk[0];
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            poll_req = (c == inject_at);
            if (dut_strobe) begin
                if (r_strobe_first < 0) r_strobe_first = c;
                r_strobe_last = c;
            end
            if (dut_busy) begin
                if (r_busy_first < 0) r_busy_first = c;
                r_busy_last = c;
            end
            if (dut_valid) begin
                r_nvalid++;
                r_valid_at = c;
                r_btn_at_valid = dut_buttons;
            end
            if (dut_overrun) r_overrun_at = c;
            if (dut_clk[0] && !prev_clk) r_npulses++;
            prev_clk = dut_clk[0];
        end
        poll_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dut_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %0b expected 0", dut_strobe); end
        n_cmp++; if (dut_clk !== 2'b00) begin n_fail++; $display("FAIL reset_clk: got %0b expected 00", dut_clk); end
        n_cmp++; if (dut_buttons !== 16'h0) begin n_fail++; $display("FAIL reset_buttons: got %0h expected 0", dut_buttons); end
        n_cmp++; if ({dut_valid, dut_busy, dut_overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %0b expected 000", {dut_valid, dut_busy, dut_overrun}); end
        n_cmp++; if (inv_clk !== 2'b11) begin n_fail++; $display("FAIL reset_inv_clk: got %0b expected 11", inv_clk); end
        n_cmp++; if (snes_buttons !== 64'h0) begin n_fail++; $display("FAIL reset_snes_buttons: got %0h expected 0", snes_buttons); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        pad_word[0] = 8'h09;   // A + START
        pad_word[1] = 8'h00;
        run_poll(0);
        n_cmp++; if (r_strobe_first !== 1 || r_strobe_last !== 12) begin n_fail++; $display("FAIL basic_strobe_window: got %0d..%0d expected 1..12", r_strobe_first, r_strobe_last); end
        n_cmp++; if (r_npulses !== 7) begin n_fail++; $display("FAIL basic_clk_pulses: got %0d expected 7", r_npulses); end
        n_cmp++; if (r_valid_at !== 103 || r_nvalid !== 1) begin n_fail++; $display("FAIL basic_valid: got cycle %0d count %0d expected cycle 103 count 1", r_valid_at, r_nvalid); end
        n_cmp++; if (r_busy_first !== 1 || r_busy_last !== 103) begin n_fail++; $display("FAIL basic_busy_window: got %0d..%0d expected 1..103", r_busy_first, r_busy_last); end
        n_cmp++; if (r_btn_at_valid !== 16'h0009) begin n_fail++; $display("FAIL basic_buttons_at_valid: got %0h expected 0009", r_btn_at_valid); end
        n_cmp++; if (dut_buttons !== 16'h0009) begin n_fail++; $display("FAIL basic_buttons_hold: got %0h expected 0009", dut_buttons); end
        n_cmp++; if (dut_pressed !== 16'h0009) begin n_fail++; $display("FAIL basic_pressed: got %0h expected 0009", dut_pressed); end
        n_cmp++; if (r_overrun_at !== -1) begin n_fail++; $display("FAIL basic_no_overrun: got cycle %0d expected none", r_overrun_at); end
    endtask

    task automatic test_repeat();
        run_poll(0);
        n_cmp++; if (dut_buttons !== 16'h0009) begin n_fail++; $display("FAIL repeat_buttons: got %0h expected 0009", dut_buttons); end
        n_cmp++; if (dut_pressed !== 16'h0000) begin n_fail++; $display("FAIL repeat_pressed: got %0h expected 0000", dut_pressed); end
        pad_word[0] = 8'h88;   // START + RIGHT, A released
        run_poll(0);
        n_cmp++; if (dut_buttons !== 16'h0088) begin n_fail++; $display("FAIL change_buttons: got %0h expected 0088", dut_buttons); end
        n_cmp++; if (dut_pressed !== 16'h0080) begin n_fail++; $display("FAIL change_pressed: got %0h expected 0080", dut_pressed); end
    endtask

    task automatic test_overrun();
        pad_word[1] = 8'h42;
        run_poll(50);
        n_cmp++; if (r_overrun_at !== 51) begin n_fail++; $display("FAIL overrun_pulse: got cycle %0d expected 51", r_overrun_at); end
        n_cmp++; if (r_nvalid !== 1 || r_valid_at !== 103) begin n_fail++; $display("FAIL overrun_valid: got cycle %0d count %0d expected cycle 103 count 1", r_valid_at, r_nvalid); end
        n_cmp++; if (r_strobe_last !== 12) begin n_fail++; $display("FAIL overrun_no_restart: got strobe end %0d expected 12", r_strobe_last); end
        n_cmp++; if (dut_buttons !== 16'h4288 || dut_pressed !== 16'h4200) begin n_fail++; $display("FAIL overrun_word: got %0h/%0h expected 4288/4200", dut_buttons, dut_pressed); end
    endtask

    task automatic test_mid_reset();
        int nval;
        @(negedge clk);
        poll_req = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            poll_req = 1'b0;
        end
        // cycle 21 lies in the first shift-clock high phase (cycles 19..24)
        n_cmp++; if (dut_clk !== 2'b11) begin n_fail++; $display("FAIL midrst_in_clk_hi: got %0b expected 11", dut_clk); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (dut_clk !== 2'b00 || dut_strobe !== 1'b0) begin n_fail++; $display("FAIL midrst_pins_idle: got clk %0b strobe %0b expected 00 0", dut_clk, dut_strobe); end
        n_cmp++; if (dut_busy !== 1'b0 || dut_buttons !== 16'h0 || dut_pressed !== 16'h0) begin n_fail++; $display("FAIL midrst_cleared: got busy %0b buttons %0h pressed %0h expected 0 0 0", dut_busy, dut_buttons, dut_pressed); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (dut_valid) nval++;
        end
        n_cmp++; if (nval !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d valid pulses expected 0", nval); end
        pad_word[0] = 8'h55;
        pad_word[1] = 8'hA0;
        run_poll(0);
        n_cmp++; if (dut_buttons !== 16'hA055 || dut_pressed !== 16'hA055) begin n_fail++; $display("FAIL midrst_next_poll: got %0h/%0h expected A055/A055", dut_buttons, dut_pressed); end
    endtask

    task automatic test_inverted();
        logic prev_clk;
        int   npulses, valid_at;
        inv_word[0] = 8'h04;   // SELECT, line high on bit 2
        inv_word[1] = 8'h81;
        npulses = 0; valid_at = -1;
        n_cmp++; if (inv_clk !== 2'b11) begin n_fail++; $display("FAIL inv_idle_high: got %0b expected 11", inv_clk); end
        @(negedge clk);
        poll_inv = 1'b1;
        @(posedge clk);
        prev_clk = inv_clk[0];
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            poll_inv = 1'b0;
            if (!inv_clk[0] && prev_clk) npulses++;
            if (inv_valid) valid_at = c;
            prev_clk = inv_clk[0];
        end
        n_cmp++; if (npulses !== 7) begin n_fail++; $display("FAIL inv_low_pulses: got %0d expected 7", npulses); end
        n_cmp++; if (valid_at !== 103) begin n_fail++; $display("FAIL inv_valid: got cycle %0d expected 103", valid_at); end
        n_cmp++; if (inv_buttons !== 16'h8104 || inv_pressed !== 16'h8104) begin n_fail++; $display("FAIL inv_word: got %0h/%0h expected 8104/8104", inv_buttons, inv_pressed); end
        n_cmp++; if (inv_buttons[2] !== 1'b1) begin n_fail++; $display("FAIL inv_bit2: got %0b expected 1", inv_buttons[2]); end
    endtask

    task automatic test_auto();
        int  t0, t1, n;
        bit  seen;
        seen = 0; n = 0; t0 = 0;
        while (!seen && n < 2500) begin
            @(negedge clk);
            n++;
            if (snes_valid) begin seen = 1; t0 = cyc; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL auto_first_valid: got none in 2500 cycles expected one"); end
        n_cmp++; if (snes_buttons !== 64'h3C5A_8000_0001_A5C3) begin n_fail++; $display("FAIL auto_word1: got %0h expected 3c5a80000001a5c3", snes_buttons); end
        snes_word[2] = 16'hC000;
        @(negedge clk);
        seen = 0; n = 0; t1 = 0;
        while (!seen && n < 2500) begin
            @(negedge clk);
            n++;
            if (snes_valid) begin seen = 1; t1 = cyc; end
        end
        n_cmp++; if (!seen || (t1 - t0) !== 1000) begin n_fail++; $display("FAIL auto_period: got %0d cycles (seen %0b) expected 1000", t1 - t0, seen); end
        n_cmp++; if (snes_buttons !== 64'h3C5A_C000_0001_A5C3) begin n_fail++; $display("FAIL auto_word2: got %0h expected 3c5ac0000001a5c3", snes_buttons); end
        n_cmp++; if (snes_pressed !== 64'h0000_4000_0000_0000) begin n_fail++; $display("FAIL auto_pressed: got %0h expected 0000400000000000", snes_pressed); end
        n_cmp++; if (snes_overrun !== 1'b0) begin n_fail++; $display("FAIL auto_overrun: got %0b expected 0", snes_overrun); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        poll_req = 1'b0; poll_inv = 1'b0; snes_poll = 1'b0;
        pad_word[0] = 8'h00; pad_word[1] = 8'h00;
        inv_word[0] = 8'h00; inv_word[1] = 8'h00;
        snes_word[0] = 16'hA5C3; snes_word[1] = 16'h0001;
        snes_word[2] = 16'h8000; snes_word[3] = 16'h3C5A;
        test_reset();
        test_basic();
        test_repeat();
        test_overrun();
        test_mid_reset();
        test_inverted();
        test_auto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
